// File: rtl/lsu_mem_stage_pkg.sv
// Shared definitions for the load/store memory stage: func3 width codes,
// FSM state encoding and the access-size decode used by the FSM and aligner.
package lsu_mem_stage_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_t;

    // Any func3 that is not a recognised byte/half code behaves as a word access.
    function automatic size_t widthOf(input logic isStore, input logic [2:0] f3);
        size_t sz;
        sz = SZ_W;
        if (isStore) begin
            if (f3 == F3_SB)      sz = SZ_B;
            else if (f3 == F3_SH) sz = SZ_H;
        end else begin
            if (f3 == F3_LB || f3 == F3_LBU)      sz = SZ_B;
            else if (f3 == F3_LH || f3 == F3_LHU) sz = SZ_H;
        end
        return sz;
    endfunction

endpackage

// File: rtl/lsu_mem_stage_if.sv
// Simple valid/ready data bus between the load/store stage (master) and memory (slave).
interface lsu_mem_stage_if #(
    parameter int ADDR_W = 32
) ();
    logic              bus_req_valid;
    logic              bus_req_ready;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [31:0]       bus_wdata;
    logic [3:0]        bus_wstrb;
    logic              bus_resp_valid;
    logic [31:0]       bus_rdata;
    logic              bus_resp_err;

    modport master (
        output bus_req_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
        input  bus_req_ready, bus_resp_valid, bus_rdata, bus_resp_err
    );

    modport slave (
        input  bus_req_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
        output bus_req_ready, bus_resp_valid, bus_rdata, bus_resp_err
    );
endinterface

// File: rtl/lsu_mem_stage_align.sv
// Combinational byte-lane placement for stores and extract/extend for loads.
module lsu_align
    import lsu_mem_stage_pkg::*;
(
    input  logic        i_isStore,
    input  logic [2:0]  i_func3,
    input  logic [1:0]  i_addrLo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);
    size_t       w_size;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_unsigned;

    assign w_size     = widthOf(i_isStore, i_func3);
    assign w_byte     = i_rdata[{i_addrLo, 3'b000} +: 8];
    assign w_half     = i_rdata[{i_addrLo[1], 4'b0000} +: 16];
    assign w_unsigned = (i_func3 == F3_LBU) || (i_func3 == F3_LHU);

    always_comb begin
        o_wstrb = 4'b0000;
        o_wdata = 32'h0;
        o_rdata = i_rdata;
        if (i_isStore) begin
            unique case (w_size)
                SZ_B: begin
                    o_wstrb = 4'b0001 << i_addrLo;
                    o_wdata = {4{i_wdata[7:0]}};
                end
                SZ_H: begin
                    o_wstrb = 4'b0011 << i_addrLo;
                    o_wdata = {2{i_wdata[15:0]}};
                end
                default: begin
                    o_wstrb = 4'b1111;
                    o_wdata = i_wdata;
                end
            endcase
        end else begin
            unique case (w_size)
                SZ_B:    o_rdata = w_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
                SZ_H:    o_rdata = w_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
                default: o_rdata = i_rdata;
            endcase
        end
    end
endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store stage: one bus transaction per instruction with misalignment,
// bus-error and timeout reporting; result held for write-back until consumed.
module lsu_mem_stage
    import lsu_mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              is_load,
    input  logic              is_store,
    input  logic [2:0]        func3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       data_out,
    output logic              err,
    lsu_mem_stage_if.master   bus
);
    localparam bit TO_EN   = (TIMEOUT_CYCLES > 0);
    localparam int CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int LAST_I  = TO_EN ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_I);

    state_t            r_state;
    state_t            w_next;
    logic              r_isStore;
    logic [2:0]        r_func3;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_data;
    logic              r_err;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_isMem;
    logic              w_misaligned;
    logic              w_timeout;
    size_t             w_inSize;
    logic [3:0]        w_laneStrb;
    logic [31:0]       w_laneWdata;
    logic [31:0]       w_loadData;

    assign w_isMem      = is_load | is_store;
    assign w_inSize     = widthOf(is_store, func3);
    assign w_misaligned = ((w_inSize == SZ_H) && addr[0]) ||
                          ((w_inSize == SZ_W) && (addr[1:0] != 2'b00));
    assign w_timeout    = TO_EN && (r_cnt == CNT_LAST) &&
                          ((r_state == ST_REQ) || (r_state == ST_WAIT));

    lsu_align u_align (
        .i_isStore (r_isStore),
        .i_func3   (r_func3),
        .i_addrLo  (r_addr[1:0]),
        .i_wdata   (r_wdata),
        .i_rdata   (bus.bus_rdata),
        .o_wstrb   (w_laneStrb),
        .o_wdata   (w_laneWdata),
        .o_rdata   (w_loadData)
    );

    // A timeout in REQ withdraws the request so no handshake can slip through as we abort.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (in_valid) w_next = (w_isMem && !w_misaligned) ? ST_REQ : ST_DONE;
            ST_REQ: begin
                if (w_timeout)              w_next = ST_DONE;
                else if (bus.bus_req_ready) w_next = ST_WAIT;
            end
            ST_WAIT: if (bus.bus_resp_valid || w_timeout) w_next = ST_DONE;
            ST_DONE: if (out_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_isStore <= 1'b0;
            r_func3   <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_data    <= '0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_cnt  <= '0;
                        r_data <= '0;
                        r_err  <= 1'b0;
                        if (w_isMem) begin
                            r_isStore <= is_store;
                            r_func3   <= func3;
                            r_addr    <= addr;
                            r_wdata   <= wdata;
                            r_err     <= w_misaligned;
                        end
                    end
                end
                ST_REQ: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_timeout) r_err <= 1'b1;
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (bus.bus_resp_valid) begin
                        r_data <= r_isStore ? 32'h0 : w_loadData;
                        r_err  <= bus.bus_resp_err;
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready          = (r_state == ST_IDLE);
    assign out_valid         = (r_state == ST_DONE);
    assign data_out          = r_data;
    assign err               = r_err;
    assign bus.bus_req_valid = (r_state == ST_REQ) && !w_timeout;
    assign bus.bus_we        = r_isStore;
    assign bus.bus_addr      = {r_addr[ADDR_W-1:2], 2'b00};
    assign bus.bus_wdata     = w_laneWdata;
    assign bus.bus_wstrb     = w_laneStrb;
endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench: table of load/store vectors through a scoreboard, plus
// timeout and mid-transaction reset sequences on a second, short-timeout instance.
module tb_lsu_mem_stage;

    typedef struct {
        bit          isLoad;
        bit          isStore;
        logic [2:0]  func3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          respErr;
        int          stall;
        int          hold;
        bit          expBus;
        bit          expWe;
        logic [3:0]  expStrb;
        logic [31:0] expBusWdata;
        logic [31:0] expBusAddr;
        logic [31:0] expData;
        bit          expErr;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        bit          err;
    } exp_t;

    localparam int NVEC = 17;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inValid = 1'b0;
    logic        isLoad = 1'b0;
    logic        isStore = 1'b0;
    logic [2:0]  func3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        outReady = 1'b0;
    logic        reqReady = 1'b0;
    logic        respValid = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic        respErr = 1'b0;

    logic        inReadyA, outValidA, errA;
    logic [31:0] dataOutA;
    logic        inReadyB, outValidB, errB;
    logic [31:0] dataOutB;

    int   errors = 0;
    int   checks = 0;
    exp_t scoreboard[$];
    vec_t vectors[NVEC];

    lsu_mem_stage_if #(.ADDR_W(32)) busA ();
    lsu_mem_stage_if #(.ADDR_W(32)) busB ();

    assign busA.bus_req_ready  = reqReady;
    assign busA.bus_resp_valid = respValid;
    assign busA.bus_rdata      = rdata;
    assign busA.bus_resp_err   = respErr;
    assign busB.bus_req_ready  = reqReady;
    assign busB.bus_resp_valid = respValid;
    assign busB.bus_rdata      = rdata;
    assign busB.bus_resp_err   = respErr;

    lsu_mem_stage #(.TIMEOUT_CYCLES(255), .ADDR_W(32)) dutA (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReadyA),
        .is_load(isLoad), .is_store(isStore), .func3(func3), .addr(addr),
        .wdata(wdata), .out_valid(outValidA), .out_ready(outReady),
        .data_out(dataOutA), .err(errA), .bus(busA)
    );

    lsu_mem_stage #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dutB (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReadyB),
        .is_load(isLoad), .is_store(isStore), .func3(func3), .addr(addr),
        .wdata(wdata), .out_valid(outValidB), .out_ready(outReady),
        .data_out(dataOutB), .err(errB), .bus(busB)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1; inValid = 1'b0; outReady = 1'b0;
        reqReady = 1'b0; respValid = 1'b0; respErr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        int   cyc;
        int   waitCnt;
        @(negedge clk);
        checkOutput("in_ready_idle", inReadyA, 1);
        inValid = 1'b1; isLoad = v.isLoad; isStore = v.isStore;
        func3 = v.func3; addr = v.addr; wdata = v.wdata;
        e.data = v.expData; e.err = v.expErr;
        scoreboard.push_back(e);
        @(negedge clk);
        inValid = 1'b0; isLoad = 1'b0; isStore = 1'b0;
        cyc = 1;
        if (v.expBus) begin
            for (int s = 0; s <= v.stall; s++) begin
                checkOutput("bus_req_valid", busA.bus_req_valid, 1);
                checkOutput("bus_we", busA.bus_we, v.expWe);
                checkOutput("bus_wstrb", busA.bus_wstrb, v.expStrb);
                checkOutput("bus_addr", busA.bus_addr, v.expBusAddr);
                if (v.isStore) checkOutput("bus_wdata", busA.bus_wdata, v.expBusWdata);
                if (s == v.stall) reqReady = 1'b1;
                @(negedge clk);
                cyc++;
            end
            reqReady = 1'b0;
            respValid = 1'b1; rdata = v.rdata; respErr = v.respErr;
            @(negedge clk);
            cyc++;
            respValid = 1'b0; respErr = 1'b0;
        end else begin
            checkOutput("no_bus_req", busA.bus_req_valid, 0);
        end
        waitCnt = 0;
        while (!outValidA && waitCnt < 20) begin
            @(negedge clk);
            cyc++;
            waitCnt++;
        end
        e = scoreboard.pop_front();
        if (!outValidA) begin
            checks++;
            errors++;
            $display("[TB] FAIL out_valid_wait: got 0 expected 1 within 20 cycles");
            return;
        end
        checkOutput("latency", 32'(cyc), v.expBus ? 32'(3 + v.stall) : 32'd1);
        checkOutput("data_out", dataOutA, e.data);
        checkOutput("err", errA, e.err);
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            checkOutput("hold_out_valid", outValidA, 1);
            checkOutput("hold_data_out", dataOutA, e.data);
            checkOutput("hold_in_ready", inReadyA, 0);
            if (!v.expBus) checkOutput("hold_no_bus_req", busA.bus_req_valid, 0);
        end
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;
        checkOutput("release_out_valid", outValidA, 0);
        checkOutput("release_in_ready", inReadyA, 1);
    endtask

    // Short-timeout instance: bus accepts at once but answers on the 4th counted cycle or never.
    task automatic timeoutRun(input bit respond);
        exp_t e;
        doReset();
        @(negedge clk);
        inValid = 1'b1; isLoad = 1'b1; isStore = 1'b0; func3 = 3'b010; addr = 32'h00000004;
        e.data = respond ? 32'h5A5A1234 : 32'h0;
        e.err  = !respond;
        scoreboard.push_back(e);
        @(negedge clk);
        inValid = 1'b0; isLoad = 1'b0;
        checkOutput("to_req_valid", busB.bus_req_valid, 1);
        reqReady = 1'b1;
        @(negedge clk);
        reqReady = 1'b0;
        checkOutput("to_wait_c1", outValidB, 0);
        @(negedge clk);
        checkOutput("to_wait_c2", outValidB, 0);
        @(negedge clk);
        checkOutput("to_wait_c3", outValidB, 0);
        if (respond) begin
            respValid = 1'b1; rdata = 32'h5A5A1234; respErr = 1'b0;
        end
        @(negedge clk);
        respValid = 1'b0;
        e = scoreboard.pop_front();
        checkOutput("to_out_valid", outValidB, 1);
        checkOutput("to_data_out", dataOutB, e.data);
        checkOutput("to_err", errB, e.err);
        checkOutput("to_req_dropped", busB.bus_req_valid, 0);
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;
        checkOutput("to_in_ready", inReadyB, 1);
        doReset();
    endtask

    task automatic resetMidWait();
        doReset();
        @(negedge clk);
        inValid = 1'b1; isLoad = 1'b1; func3 = 3'b010; addr = 32'h00000008;
        @(negedge clk);
        inValid = 1'b0; isLoad = 1'b0;
        reqReady = 1'b1;
        @(negedge clk);
        reqReady = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        respValid = 1'b1; rdata = 32'hFFFFFFFF;
        @(negedge clk);
        respValid = 1'b0;
        checkOutput("rst_out_valid", outValidA, 0);
        checkOutput("rst_in_ready", inReadyA, 1);
        checkOutput("rst_req_valid", busA.bus_req_valid, 0);
        @(negedge clk);
        checkOutput("rst_out_valid_late", outValidA, 0);
        checkOutput("rst_data_out", dataOutA, 32'h0);
    endtask

    initial begin
        // isLoad isStore f3 addr wdata rdata respErr stall hold expBus expWe strb busWdata busAddr data err
        vectors[0]  = '{1, 0, 3'b010, 32'h80000004, 32'h0, 32'hDEADBEEF, 0, 0, 5, 1, 0, 4'b0000, 32'h0, 32'h80000004, 32'hDEADBEEF, 0};
        vectors[1]  = '{1, 0, 3'b000, 32'h80000003, 32'h0, 32'h80FF7F01, 0, 0, 0, 1, 0, 4'b0000, 32'h0, 32'h80000000, 32'hFFFFFF80, 0};
        vectors[2]  = '{1, 0, 3'b100, 32'h80000003, 32'h0, 32'h80FF7F01, 0, 0, 0, 1, 0, 4'b0000, 32'h0, 32'h80000000, 32'h00000080, 0};
        vectors[3]  = '{1, 0, 3'b101, 32'h80000002, 32'h0, 32'h80FF7F01, 0, 0, 0, 1, 0, 4'b0000, 32'h0, 32'h80000000, 32'h000080FF, 0};
        vectors[4]  = '{1, 0, 3'b001, 32'h80000002, 32'h0, 32'h80FF7F01, 0, 0, 0, 1, 0, 4'b0000, 32'h0, 32'h80000000, 32'hFFFF80FF, 0};
        vectors[5]  = '{1, 0, 3'b001, 32'h80000000, 32'h0, 32'h80FF7F01, 0, 0, 0, 1, 0, 4'b0000, 32'h0, 32'h80000000, 32'h00007F01, 0};
        vectors[6]  = '{1, 0, 3'b000, 32'h80000001, 32'h0, 32'h80FF7F01, 0, 0, 0, 1, 0, 4'b0000, 32'h0, 32'h80000000, 32'h0000007F, 0};
        vectors[7]  = '{0, 1, 3'b001, 32'h10000002, 32'h1234ABCD, 32'h0, 0, 3, 0, 1, 1, 4'b1100, 32'hABCDABCD, 32'h10000000, 32'h0, 0};
        vectors[8]  = '{0, 1, 3'b000, 32'h10000001, 32'h000000A5, 32'h0, 0, 0, 0, 1, 1, 4'b0010, 32'hA5A5A5A5, 32'h10000000, 32'h0, 0};
        vectors[9]  = '{0, 1, 3'b010, 32'h10000008, 32'hCAFEF00D, 32'h0, 0, 0, 0, 1, 1, 4'b1111, 32'hCAFEF00D, 32'h10000008, 32'h0, 0};
        vectors[10] = '{1, 0, 3'b010, 32'h20000000, 32'h0, 32'h11223344, 1, 0, 0, 1, 0, 4'b0000, 32'h0, 32'h20000000, 32'h11223344, 1};
        vectors[11] = '{1, 0, 3'b010, 32'h80000001, 32'h0, 32'h0, 0, 0, 2, 0, 0, 4'b0000, 32'h0, 32'h0, 32'h0, 1};
        vectors[12] = '{1, 0, 3'b001, 32'h80000003, 32'h0, 32'h0, 0, 0, 0, 0, 0, 4'b0000, 32'h0, 32'h0, 32'h0, 1};
        vectors[13] = '{0, 1, 3'b010, 32'h10000002, 32'h55667788, 32'h0, 0, 0, 0, 0, 0, 4'b0000, 32'h0, 32'h0, 32'h0, 1};
        vectors[14] = '{0, 0, 3'b000, 32'h00000000, 32'h0, 32'h0, 0, 0, 0, 0, 0, 4'b0000, 32'h0, 32'h0, 32'h0, 0};
        vectors[15] = '{1, 0, 3'b011, 32'h00000040, 32'h0, 32'h01020304, 0, 0, 0, 1, 0, 4'b0000, 32'h0, 32'h00000040, 32'h01020304, 0};
        vectors[16] = '{0, 1, 3'b000, 32'h30000003, 32'h0000007E, 32'h0, 0, 0, 0, 1, 1, 4'b1000, 32'h7E7E7E7E, 32'h30000000, 32'h0, 0};

        doReset();
        @(negedge clk);
        checkOutput("reset_in_ready", inReadyA, 1);
        checkOutput("reset_out_valid", outValidA, 0);
        checkOutput("reset_data_out", dataOutA, 32'h0);
        checkOutput("reset_err", errA, 0);
        checkOutput("reset_req_valid", busA.bus_req_valid, 0);
        checkOutput("reset_we", busA.bus_we, 0);
        checkOutput("reset_wstrb", busA.bus_wstrb, 0);
        checkOutput("reset_addr", busA.bus_addr, 32'h0);
        checkOutput("reset_wdata", busA.bus_wdata, 32'h0);

        for (int i = 0; i < NVEC; i++) begin
            $display("[TB] vector %0d", i);
            applyStimulus(vectors[i]);
        end

        $display("[TB] timeout with no response");
        timeoutRun(1'b0);
        $display("[TB] response on the last counted cycle");
        timeoutRun(1'b1);
        $display("[TB] reset while waiting for a response");
        resetMidWait();

        checkOutput("scoreboard_empty", 32'(scoreboard.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
Load/store stage sitting directly upstream of the write-back stage. It takes the effective address and store data from execute, runs one transaction per instruction on a simple valid/ready data bus, and aligns and extends load data. It presents the result as data_out to write-back, which selects it for LW-class opcodes. Adds multi-cycle memory latency and error reporting to the core.

Parameters:
TIMEOUT_CYCLES, 255, bus cycles (REQ+WAIT) before a transaction is aborted with err; 0 disables timeout
ADDR_W, 32, address width

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  execute offers a memory op
in_ready  out  1  stage can accept (state IDLE)
is_load  in  1  op is a load
is_store  in  1  op is a store (is_load and is_store never both 1)
func3  in  3  width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
addr  in  ADDR_W  effective address (alu_result)
wdata  in  32  rs2 value for stores
out_valid  out  1  result ready for write-back
out_ready  in  1  write-back consumes result
data_out  out  32  aligned and extended load data; 0 for stores
err  out  1  misaligned access or bus error or timeout, valid with out_valid
bus_req_valid  out  1  bus request
bus_req_ready  in  1  bus accepts request
bus_we  out  1  1 = write
bus_addr  out  ADDR_W  word-aligned address (addr[1:0] forced 0)
bus_wdata  out  32  store data shifted to byte lane
bus_wstrb  out  4  byte enables (0 for reads)
bus_resp_valid  in  1  bus response
bus_rdata  in  32  read word
bus_resp_err  in  1  bus error with response

Behaviour:
- Reset (sync, rst=1 at a clk edge): state IDLE; all outputs 0 except in_ready=1; timeout counter 0; latched fields 0.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: in_ready=1. On in_valid with is_load|is_store: latch is_store, func3, addr, wdata. If misaligned (H/HU with addr[0]=1, W with addr[1:0]!=0), go to DONE with err=1 and no bus traffic; otherwise go to REQ. in_valid with neither flag set: go to DONE with data_out=0, err=0 (pass-through).
- REQ: bus_req_valid=1 with stable bus_we/addr/wdata/wstrb until bus_req_ready; then WAIT.
- WAIT: on bus_resp_valid, latch data_out (loads) and err=bus_resp_err; go to DONE. Responses in other states are ignored.
- DONE: out_valid=1, data_out/err held stable until out_ready; then IDLE. The next request is accepted no earlier than the following cycle.
- Minimum latency, aligned op with zero-wait bus: accept at cycle 0, REQ at 1, WAIT at 2, resp at 2, out_valid at 3.
- Store lanes: SB: wstrb=0001<<addr[1:0], wdata byte replicated x4. SH: wstrb=0011<<addr[1:0], halfword replicated x2. SW: 1111.
- Load extract: byte = rdata[8*addr[1:0]+:8], half = rdata[16*addr[1]+:16]. B/H sign-extend, BU/HU zero-extend, W unchanged. Unknown func3 is treated as W.
- Timeout: counter increments each cycle in REQ or WAIT and clears on entering REQ. When count reaches TIMEOUT_CYCLES, go to DONE with err=1 and bus_req_valid deasserted. If bus_resp_valid arrives in the same cycle as the timeout, the response wins.
- rst mid-transaction: return to IDLE immediately. A late bus response after reset is ignored.

Decomposition:
- Shared defines file holds the func3 width codes (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU, F3_SB, F3_SH, F3_SW) and the FSM state encodings.
- One combinational sub-module, lsu_align: computes wstrb/wdata lane placement and load extract/extend from func3, addr[1:0] and rdata. The FSM stays in lsu_mem_stage.

Test Plan:
- LW addr=0x80000004, bus returns 0xDEADBEEF zero-wait -> bus_addr=0x80000004, wstrb=0, out_valid at cycle 3, data_out=0xDEADBEEF, err=0.
- LB addr=0x80000003, rdata=0x80FF7F01 -> data_out=0xFFFFFF80; LBU same -> 0x00000080; LHU addr=0x80000002 -> 0x000080FF.
- SH addr=0x10000002, wdata=0x1234ABCD -> bus_we=1, wstrb=1100, wdata=0xABCDABCD, bus_addr=0x10000000; out data_out=0.
- LW addr=0x80000001 -> no bus_req_valid ever; out_valid next cycle with err=1. Bus_req_ready held low 3 cycles -> request fields stable throughout.
- TIMEOUT_CYCLES=4, bus never responds -> err=1, out_valid after 4 counted cycles. Second run: response arrives on the 4th cycle -> err=0 with the bus data.
- rst asserted while in WAIT, then bus_resp_valid next cycle -> state IDLE, out_valid stays 0, in_ready=1. Also hold out_ready=0 for 5 cycles in DONE -> data_out stable, in_ready=0.
